// File: rtl/guard_reset_sequencer.sv
// Guard reset sequencer: recovery controller between the write/read guards
// and the guarded AXI slave port. A guard reset request isolates the slave,
// drains (or times out) outstanding traffic, pulses the slave reset for a
// counted number of cycles, then returns a one-cycle clear to every guard
// that took part in the sequence. Also owns the sticky irq and cause status.
//
// Optional feature macro: GUARD_SEQ_SW_ACK_EN
//   Defined   -> adds sw_ack_i and a HOLD state after RESET; the sequence
//                waits there (slave out of reset, still blocked) until
//                software acknowledges, then issues the clear.
//   Undefined -> RESET goes straight to CLEAR, no sw_ack_i port.
module guard_reset_sequencer #(
    parameter int NumGuards    = 2,
    parameter int RstCycles    = 16,
    parameter int DrainTimeout = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumGuards-1:0] guard_reset_req_i,
    output logic [NumGuards-1:0] guard_reset_clear_o,
    input  logic [NumGuards-1:0] en_i,
    output logic [NumGuards-1:0] guard_en_o,
    input  logic                 txn_pending_i,
    output logic                 block_o,
    output logic                 slv_rst_o,
    output logic                 irq_o,
    input  logic                 irq_clear_i,
    output logic [NumGuards-1:0] cause_o,
    output logic                 drain_timeout_o,
    output logic [2:0]           state_o
`ifdef GUARD_SEQ_SW_ACK_EN
    ,
    input  logic                 sw_ack_i
`endif
);

    // One down-counter is shared by DRAIN (timeout) and RESET (pulse length),
    // so it is sized for the larger of the two loads.
    localparam int MaxCnt   = (RstCycles > DrainTimeout) ? RstCycles : DrainTimeout;
    localparam int CntWidth = $clog2(MaxCnt + 1);

    localparam logic [CntWidth-1:0] DrainLoad = CntWidth'(DrainTimeout - 1);
    localparam logic [CntWidth-1:0] RstLoad   = CntWidth'(RstCycles - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISOLATE = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_RESET   = 3'd3,
        ST_CLEAR   = 3'd4
`ifdef GUARD_SEQ_SW_ACK_EN
        ,
        ST_HOLD    = 3'd5
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [NumGuards-1:0]  cause_q, cause_d;
    logic                  irq_q, irq_d;
    logic                  dto_q, dto_d;
    logic                  block_q;
    logic                  slv_rst_q;
    logic [NumGuards-1:0]  clear_q;

    // Next-state, counter and status update logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        irq_d   = irq_q;
        dto_d   = dto_q;

        // Software clear first so that a coincident IDLE trigger below wins.
        if (irq_clear_i) begin
            irq_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (|guard_reset_req_i) begin
                    state_d = ST_ISOLATE;
                    cause_d = guard_reset_req_i;
                    irq_d   = 1'b1;
                    dto_d   = 1'b0;
                end
            end
            ST_ISOLATE: begin
                cause_d = cause_q | guard_reset_req_i;
                cnt_d   = DrainLoad;
                state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                cause_d = cause_q | guard_reset_req_i;
                // An empty port wins over a timeout landing in the same cycle.
                if (!txn_pending_i) begin
                    state_d = ST_RESET;
                    cnt_d   = RstLoad;
                end else if (cnt_q == '0) begin
                    dto_d   = 1'b1;
                    state_d = ST_RESET;
                    cnt_d   = RstLoad;
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
            ST_RESET: begin
                if (cnt_q == '0) begin
`ifdef GUARD_SEQ_SW_ACK_EN
                    state_d = ST_HOLD;
`else
                    state_d = ST_CLEAR;
`endif
                end else begin
                    cnt_d = cnt_q - CntWidth'(1);
                end
            end
`ifdef GUARD_SEQ_SW_ACK_EN
            ST_HOLD: begin
                if (sw_ack_i) begin
                    state_d = ST_CLEAR;
                end
            end
`endif
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counter, status and registered outputs (derived from next state).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            cause_q   <= '0;
            irq_q     <= 1'b0;
            dto_q     <= 1'b0;
            block_q   <= 1'b0;
            slv_rst_q <= 1'b0;
            clear_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            irq_q     <= irq_d;
            dto_q     <= dto_d;
            block_q   <= (state_d != ST_IDLE);
            slv_rst_q <= (state_d == ST_RESET);
            clear_q   <= (state_d == ST_CLEAR) ? cause_d : '0;
        end
    end

    // Enqueue gating is combinational so new traffic stops the cycle we leave IDLE.
    assign guard_en_o          = (state_q == ST_IDLE) ? en_i : '0;
    assign block_o             = block_q;
    assign slv_rst_o           = slv_rst_q;
    assign guard_reset_clear_o = clear_q;
    assign irq_o               = irq_q;
    assign cause_o             = cause_q;
    assign drain_timeout_o     = dto_q;
    assign state_o             = state_q;

endmodule
